// File: rtl/memory_access_arbiter.sv
// Round-robin arbiter sharing one small single-port memory between two byte requesters.
// Each accepted command takes one ACCESS cycle at the memory and one DONE cycle to report back.
module memory_access_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_store,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              owner;
    logic              last_grant;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] hold0;
    logic [DATA_W-1:0] hold1;
    logic              accept;
    logic              winner;
    logic              done0;
    logic              done1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake and strobe outputs are all masked during reset so a reset
    // cycle can neither accept, store nor complete anything.
    always_comb begin
        state_next = state;
        winner     = 1'b0;
        accept     = 1'b0;
        r0_ready   = 1'b0;
        r1_ready   = 1'b0;
        mem_store  = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (r0_valid && r1_valid) begin
                        winner = !last_grant;
                    end else begin
                        winner = r1_valid;
                    end
                    accept   = r0_valid | r1_valid;
                    r0_ready = accept & !winner;
                    r1_ready = accept & winner;
                    if (accept) begin
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                mem_store  = cmd_we & !reset;
                state_next = DONE;
            end
            DONE: begin
                done0      = !owner & !reset;
                done1      = owner & !reset;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            rdata      <= '0;
            hold0      <= '0;
            hold1      <= '0;
        end else begin
            if (accept) begin
                owner      <= winner;
                last_grant <= winner;
                cmd_we     <= winner ? r1_we    : r0_we;
                cmd_addr   <= winner ? r1_addr  : r0_addr;
                cmd_wdata  <= winner ? r1_wdata : r0_wdata;
            end
            if (state == ACCESS) begin
                rdata <= cmd_we ? cmd_wdata : mem_q;
            end
            // Per-requester copies keep each rdata port stable between its own completions.
            if (done0) begin
                hold0 <= rdata;
            end
            if (done1) begin
                hold1 <= rdata;
            end
        end
    end

    assign mem_addr  = cmd_addr;
    assign mem_data  = cmd_wdata;
    assign busy      = (state != IDLE);
    assign r0_rvalid = done0;
    assign r1_rvalid = done1;
    assign r0_rdata  = done0 ? rdata : hold0;
    assign r1_rdata  = done1 ? rdata : hold1;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Bench for memory_access_arbiter: directed vector table, corner-case sequences and
// randomized traffic, all checked cycle by cycle against a transaction-level reference model.
module tb_memory_access_arbiter;

    logic       clk;
    logic       reset;
    logic       r0_valid, r0_ready, r0_we, r0_rvalid;
    logic [1:0] r0_addr;
    logic [7:0] r0_wdata, r0_rdata;
    logic       r1_valid, r1_ready, r1_we, r1_rvalid;
    logic [1:0] r1_addr;
    logic [7:0] r1_wdata, r1_rdata;
    logic [7:0] mem_data, mem_q;
    logic       mem_store, busy;
    logic [1:0] mem_addr;

    logic [7:0] tb_mem [4] = '{default: 8'h00};

    memory_access_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_data(mem_data), .mem_store(mem_store), .mem_addr(mem_addr), .mem_q(mem_q),
        .busy(busy)
    );

    // Stand-in for memory_system: combinational read, write on the rising edge.
    assign mem_q = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_store) tb_mem[mem_addr] <= mem_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Reference model: commands are transactions with an accept cycle; the store
    // happens one cycle later, the completion two cycles later, next accept three later.
    int         cyc = 0;
    int         free_at = 0;
    bit         last = 1'b1;
    bit         infl = 1'b0;
    int         acc_t = 0;
    bit         iowner, iwe;
    logic [1:0] iaddr;
    logic [7:0] iwdata, idata;
    logic [7:0] held [2] = '{default: 8'h00};
    logic [1:0] cur_addr = 2'd0;
    logic [7:0] ref_mem [4] = '{default: 8'h00};
    logic       m0, m1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_check(output logic acc0, output logic acc1);
        logic [1:0] er, ev;
        logic       es;
        int         w;
        logic [7:0] erd0, erd1;
        er = 2'b00; ev = 2'b00; es = 1'b0; w = -1;
        if (!reset && cyc >= free_at) begin
            if (r0_valid && r1_valid) w = last ? 0 : 1;
            else if (r0_valid)        w = 0;
            else if (r1_valid)        w = 1;
        end
        if (w >= 0) er[w] = 1'b1;
        if (infl && cyc == acc_t + 1) begin
            es = iwe && !reset;
            chk("m_mem_data", mem_data, iwdata);
        end
        if (infl && cyc == acc_t + 2 && !reset) ev[iowner] = 1'b1;
        erd0 = ev[0] ? idata : held[0];
        erd1 = ev[1] ? idata : held[1];
        chk("m_r0_ready", r0_ready, er[0]);
        chk("m_r1_ready", r1_ready, er[1]);
        chk("m_mem_store", mem_store, es);
        chk("m_r0_rvalid", r0_rvalid, ev[0]);
        chk("m_r1_rvalid", r1_rvalid, ev[1]);
        chk("m_r0_rdata", r0_rdata, erd0);
        chk("m_r1_rdata", r1_rdata, erd1);
        chk("m_busy", busy, (cyc < free_at));
        chk("m_mem_addr", mem_addr, cur_addr);
        acc0 = er[0];
        acc1 = er[1];
        if (reset) begin
            infl = 1'b0; free_at = cyc + 1; last = 1'b1;
            held[0] = 8'h00; held[1] = 8'h00; cur_addr = 2'd0;
        end else begin
            if (infl && cyc == acc_t + 1) begin
                idata = iwe ? iwdata : ref_mem[iaddr];
                if (iwe) ref_mem[iaddr] = iwdata;
            end
            if (infl && cyc == acc_t + 2) begin
                held[iowner] = idata;
                infl = 1'b0;
            end
            if (w >= 0) begin
                infl = 1'b1; acc_t = cyc; iowner = (w == 1); last = (w == 1);
                free_at = cyc + 3;
                iwe    = (w == 1) ? r1_we    : r0_we;
                iaddr  = (w == 1) ? r1_addr  : r0_addr;
                iwdata = (w == 1) ? r1_wdata : r0_wdata;
                cur_addr = iaddr;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cycle();
        @(negedge clk);
        model_check(m0, m1);
        tick();
    endtask

    task automatic set_req(input int n, input int v, input int we, input int a, input int d);
        if (n == 0) begin
            r0_valid = 1'(v); r0_we = 1'(we); r0_addr = 2'(a); r0_wdata = 8'(d);
        end else begin
            r1_valid = 1'(v); r1_we = 1'(we); r1_addr = 2'(a); r1_wdata = 8'(d);
        end
    endtask

    // One complete command for requester n; returns the data reported on completion.
    task automatic run_cmd(input int n, input int we, input int a, input int d, output logic [7:0] rd);
        bit got;
        got = 1'b0;
        rd  = 8'h00;
        set_req(n, 1, we, a, d);
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            got = (n == 0) ? r0_ready : r1_ready;
            model_check(m0, m1);
            tick();
        end
        if (!got) chk("cmd_accept_timeout", 0, 1);
        set_req(n, 0, 0, 0, 0);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if ((n == 0) ? r0_rvalid : r1_rvalid) begin
                got = 1'b1;
                rd  = (n == 0) ? r0_rdata : r1_rdata;
            end
            model_check(m0, m1);
            tick();
        end
        if (!got) chk("cmd_rvalid_timeout", 0, 1);
    endtask

    typedef struct packed {
        logic       v0, we0;
        logic [1:0] a0;
        logic [7:0] d0;
        logic       v1, we1;
        logic [1:0] a1;
        logic [7:0] d1;
        logic       rdy0, rdy1, st;
        logic [1:0] ma;
        logic [7:0] md;
        logic       bsy, rv0, rv1;
        logic [7:0] rd0, rd1;
    } vec_t;

    function automatic vec_t mk(int v0, int we0, int a0, int d0, int v1, int we1, int a1, int d1,
                                int rdy0, int rdy1, int st, int ma, int md, int bsy,
                                int rv0, int rv1, int rd0, int rd1);
        vec_t r;
        r.v0 = 1'(v0); r.we0 = 1'(we0); r.a0 = 2'(a0); r.d0 = 8'(d0);
        r.v1 = 1'(v1); r.we1 = 1'(we1); r.a1 = 2'(a1); r.d1 = 8'(d1);
        r.rdy0 = 1'(rdy0); r.rdy1 = 1'(rdy1); r.st = 1'(st); r.ma = 2'(ma); r.md = 8'(md);
        r.bsy = 1'(bsy); r.rv0 = 1'(rv0); r.rv1 = 1'(rv1); r.rd0 = 8'(rd0); r.rd1 = 8'(rd1);
        return r;
    endfunction

    vec_t       vecs [8];
    logic [7:0] rd;
    int         nacc, last_acc, who;
    bit         p0, p1;
    logic [31:0] rnd;
    logic [7:0]  t4_exp [4];

    initial begin
        // v0 we0 a0 d0 | v1 we1 a1 d1 | rdy0 rdy1 st ma md bsy rv0 rv1 rd0 rd1
        vecs[0] = mk(0,0,0,'h00, 0,0,0,'h00, 0,0,0,0,'h00, 0,0,0,'h00,'h00);
        vecs[1] = mk(1,1,2,'hA5, 0,0,0,'h00, 1,0,0,0,'h00, 0,0,0,'h00,'h00);
        vecs[2] = mk(0,0,0,'h00, 0,0,0,'h00, 0,0,1,2,'hA5, 1,0,0,'h00,'h00);
        vecs[3] = mk(0,0,0,'h00, 0,0,0,'h00, 0,0,0,2,'hA5, 1,1,0,'hA5,'h00);
        vecs[4] = mk(0,0,0,'h00, 1,0,2,'h00, 0,1,0,2,'hA5, 0,0,0,'hA5,'h00);
        vecs[5] = mk(0,0,0,'h00, 0,0,0,'h00, 0,0,0,2,'h00, 1,0,0,'hA5,'h00);
        vecs[6] = mk(0,0,0,'h00, 0,0,0,'h00, 0,0,0,2,'h00, 1,0,1,'hA5,'hA5);
        vecs[7] = mk(0,0,0,'h00, 0,0,0,'h00, 0,0,0,2,'h00, 0,0,0,'hA5,'hA5);

        reset = 1'b1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        tick();
        tick();
        do_cycle();
        reset = 1'b0;

        // Reset state, single write by r0, then read-back by r1.
        for (int i = 0; i < 8; i++) begin
            set_req(0, vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0);
            set_req(1, vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            chk($sformatf("vec%0d_r0_ready", i), r0_ready, vecs[i].rdy0);
            chk($sformatf("vec%0d_r1_ready", i), r1_ready, vecs[i].rdy1);
            chk($sformatf("vec%0d_mem_store", i), mem_store, vecs[i].st);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].ma);
            if (vecs[i].bsy && !vecs[i].rv0 && !vecs[i].rv1)
                chk($sformatf("vec%0d_mem_data", i), mem_data, vecs[i].md);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
            chk($sformatf("vec%0d_r0_rvalid", i), r0_rvalid, vecs[i].rv0);
            chk($sformatf("vec%0d_r1_rvalid", i), r1_rvalid, vecs[i].rv1);
            chk($sformatf("vec%0d_r0_rdata", i), r0_rdata, vecs[i].rd0);
            chk($sformatf("vec%0d_r1_rdata", i), r1_rdata, vecs[i].rd1);
            model_check(m0, m1);
            tick();
        end

        // Continuous tie: grants alternate starting with r0, one every 3 cycles.
        set_req(0, 1, 1, 0, 'h30);
        set_req(1, 1, 1, 1, 'h40);
        nacc = 0;
        last_acc = -10;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            who = r0_ready ? 0 : (r1_ready ? 1 : -1);
            chk("t3_busy", busy, (who < 0));
            if (who >= 0) begin
                chk("t3_order", who, nacc % 2);
                if (nacc > 0) chk("t3_gap", c - last_acc, 3);
                last_acc = c;
                nacc++;
            end
            model_check(m0, m1);
            tick();
            if (who == 0) set_req(0, 1, 1, 0, 'h30 + nacc);
            if (who == 1) set_req(1, 1, 1, 1, 'h40 + nacc);
        end
        chk("t3_count", nacc, 4);
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);

        // r1 fills the memory, r0 reads it back.
        t4_exp[0] = 8'h11; t4_exp[1] = 8'h22; t4_exp[2] = 8'h33; t4_exp[3] = 8'h44;
        for (int a = 0; a < 4; a++) run_cmd(1, 1, a, t4_exp[a], rd);
        for (int a = 0; a < 4; a++) begin
            run_cmd(0, 0, a, 0, rd);
            chk($sformatf("t4_rdata_addr%0d", a), rd, t4_exp[a]);
        end

        // Reset lands in the ACCESS cycle of a write.
        set_req(0, 1, 1, 1, 'hFF);
        @(negedge clk);
        chk("t5_accept", r0_ready, 1);
        model_check(m0, m1);
        tick();
        set_req(0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_store_in_reset", mem_store, 0);
        model_check(m0, m1);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_no_rvalid", r0_rvalid, 0);
            model_check(m0, m1);
            tick();
        end
        chk("t5_mem1_unchanged", tb_mem[1], 8'h22);
        set_req(0, 1, 0, 3, 0);
        set_req(1, 1, 0, 3, 0);
        @(negedge clk);
        chk("t5_tie_r0_ready", r0_ready, 1);
        chk("t5_tie_r1_ready", r1_ready, 0);
        model_check(m0, m1);
        tick();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        do_cycle();
        do_cycle();

        // r0 holds a write while r1 (granted by round robin) is served.
        set_req(0, 1, 1, 0, 'h5A);
        set_req(1, 1, 0, 3, 0);
        @(negedge clk);
        chk("t6_r1_ready", r1_ready, 1);
        chk("t6_r0_blocked", r0_ready, 0);
        model_check(m0, m1);
        tick();
        set_req(1, 0, 1, 2, 'hEE);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("t6_r0_wait", r0_ready, 0);
            model_check(m0, m1);
            tick();
        end
        @(negedge clk);
        chk("t6_r0_accept", r0_ready, 1);
        model_check(m0, m1);
        tick();
        set_req(0, 0, 0, 3, 'h00);
        @(negedge clk);
        chk("t6_store", mem_store, 1);
        chk("t6_addr", mem_addr, 0);
        chk("t6_data", mem_data, 8'h5A);
        model_check(m0, m1);
        tick();
        do_cycle();
        do_cycle();

        // Randomized traffic with occasional resets; a pending command is held until accepted.
        p0 = 1'b0;
        p1 = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(59, 0) == 0);
            if (!p0) begin
                rnd = $urandom;
                r0_valid = (rnd[12:11] != 2'b00); r0_we = rnd[0];
                r0_addr = rnd[2:1]; r0_wdata = rnd[10:3];
            end
            if (!p1) begin
                rnd = $urandom;
                r1_valid = (rnd[12:11] != 2'b00); r1_we = rnd[0];
                r1_addr = rnd[2:1]; r1_wdata = rnd[10:3];
            end
            @(negedge clk);
            model_check(m0, m1);
            tick();
            p0 = r0_valid && !m0;
            p1 = r1_valid && !m1;
        end
        reset = 1'b0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) do_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
